// File: rtl/axis_width_downsizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_width_downsizer_pkg
// Description : Shared stream widths, downsizer state encoding and clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_width_downsizer_pkg;

    localparam int AXIS_WORD_W = 32;
    localparam int AXIS_BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ds_state_t;

    function automatic int axis_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : axis_width_downsizer_pkg
`default_nettype wire

// File: rtl/axis_width_downsizer_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_width_downsizer_if
// Description : Valid/ready stream bundle; slave side consumes, master side emits.
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_width_downsizer_if
    import axis_width_downsizer_pkg::*;
#(
    parameter int DATA_W = AXIS_WORD_W
);
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tready;
    logic              tlast_slice;

    modport master (
        output tvalid,
        output tdata,
        output tlast_slice,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );

endinterface : axis_width_downsizer_if
`default_nettype wire

// File: rtl/axis_width_downsizer.sv
`default_nettype none
// ============================================================================
// Module      : axis_width_downsizer
// Description : Splits each accepted wide word into RATIO narrow beats, LS first.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_width_downsizer
    import axis_width_downsizer_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = AXIS_WORD_W,
    parameter int C_M_AXIS_TDATA_WIDTH = AXIS_BYTE_W
)(
    input  logic                    clk,
    input  logic                    rstn,
    axis_width_downsizer_if.slave   s_axis,
    axis_width_downsizer_if.master  m_axis
);

    localparam int RATIO   = C_S_AXIS_TDATA_WIDTH / C_M_AXIS_TDATA_WIDTH;
    localparam int CLOG_R  = axis_clog2(RATIO);
    localparam int CNT_W   = (CLOG_R < 1) ? 1 : CLOG_R;
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(RATIO - 1);

    generate
        if ((RATIO < 2) || ((C_S_AXIS_TDATA_WIDTH % C_M_AXIS_TDATA_WIDTH) != 0)) begin : g_bad_ratio
            $error("axis_width_downsizer: input width must be >= 2x and a multiple of output width");
        end
    endgenerate

    ds_state_t                          r_state;
    ds_state_t                          w_state_nxt;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]    r_word;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]    w_word_nxt;
    logic [CNT_W-1:0]                   r_idx;
    logic [CNT_W-1:0]                   w_idx_nxt;

    logic                               w_full;
    logic                               w_last;
    logic                               w_s_ready;
    logic                               w_in_hs;
    logic                               w_out_hs;
    logic [RATIO-1:0][C_M_AXIS_TDATA_WIDTH-1:0] w_slices;

    assign w_full    = (r_state == ST_FULL);
    assign w_last    = (r_idx == C_LAST_IDX);
    // Ready looks through to downstream so the last slice can drain and refill in one cycle
    assign w_s_ready = ~w_full | (m_axis.tready & w_last);
    assign w_in_hs   = s_axis.tvalid & w_s_ready;
    assign w_out_hs  = w_full & m_axis.tready;
    assign w_slices  = r_word;

    assign s_axis.tready      = w_s_ready;
    assign m_axis.tvalid      = w_full;
    assign m_axis.tdata       = w_slices[r_idx];
    assign m_axis.tlast_slice = w_full & w_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_EMPTY;
            r_word  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_hs) begin
                    w_word_nxt  = s_axis.tdata;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_out_hs) begin
                    if (!w_last) begin
                        w_idx_nxt = r_idx + CNT_W'(1);
                    end else if (w_in_hs) begin
                        w_word_nxt = s_axis.tdata;
                        w_idx_nxt  = '0;
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_idx_nxt   = '0;
            end
        endcase
    end

endmodule : axis_width_downsizer
`default_nettype wire

// File: tb/tb_axis_width_downsizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_width_downsizer
// Description : Directed and randomized self-checking bench for the downsizer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_width_downsizer;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_fail;
    int   words_in;
    int   cyc;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    axis_width_downsizer_if #(.DATA_W(32)) s_if();
    axis_width_downsizer_if #(.DATA_W(8))  m_if();

    axis_width_downsizer #(
        .C_S_AXIS_TDATA_WIDTH (32),
        .C_M_AXIS_TDATA_WIDTH (8)
    ) u_dut (
        .clk    (clk),
        .rstn   (rstn),
        .s_axis (s_if.slave),
        .m_axis (m_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        s_if.tlast_slice = 1'b0;
        rstn = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'hCAFEF00D;
        m_if.tready = 1'b1;

        // Reset held with valid asserted: nothing may be captured
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_tvalid", m_if.tvalid, 1'b0);
            chk("rst_tdata", m_if.tdata, 8'h00);
        end

        // Release and send a single word with downstream always ready
        s_if.tdata = 32'hDDCCBBAA;
        rstn = 1'b1;
        #1;
        chk("rel_s_tready", s_if.tready, 1'b1);
        chk("rel_tvalid", m_if.tvalid, 1'b0);
        tick();
        s_if.tvalid = 1'b0;
        chk("sw_b0", m_if.tdata, 8'hAA);
        chk("sw_v0", m_if.tvalid, 1'b1);
        chk("sw_l0", m_if.tlast_slice, 1'b0);
        tick();
        chk("sw_b1", m_if.tdata, 8'hBB);
        chk("sw_l1", m_if.tlast_slice, 1'b0);
        tick();
        chk("sw_b2", m_if.tdata, 8'hCC);
        chk("sw_l2", m_if.tlast_slice, 1'b0);
        tick();
        chk("sw_b3", m_if.tdata, 8'hDD);
        chk("sw_l3", m_if.tlast_slice, 1'b1);
        chk("sw_s_tready_last", s_if.tready, 1'b1);
        tick();
        chk("sw_idle", m_if.tvalid, 1'b0);

        // Back-to-back words with no bubble
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h03020100;
        tick();
        s_if.tdata  = 32'h07060504;
        #1;
        chk("b2b_s_tready_mid", s_if.tready, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_data", m_if.tdata, 32'(i));
            chk("b2b_valid", m_if.tvalid, 1'b1);
            chk("b2b_last", m_if.tlast_slice, (i % 4) == 3);
            if (i == 3) chk("b2b_refill_ready", s_if.tready, 1'b1);
            tick();
            if (i == 3) s_if.tvalid = 1'b0;
        end
        chk("b2b_idle", m_if.tvalid, 1'b0);

        // Downstream stall while the second slice is presented
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'hDDCCBBAA;
        tick();
        s_if.tvalid = 1'b0;
        chk("st_b0", m_if.tdata, 8'hAA);
        tick();
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h5A5A5A5A;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("st_hold_data", m_if.tdata, 8'hBB);
            chk("st_s_tready", s_if.tready, 1'b0);
            tick();
        end
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        #1;
        chk("st_rel_b1", m_if.tdata, 8'hBB);
        tick();
        chk("st_b2", m_if.tdata, 8'hCC);
        tick();
        chk("st_b3", m_if.tdata, 8'hDD);
        chk("st_l3", m_if.tlast_slice, 1'b1);
        tick();
        chk("st_idle", m_if.tvalid, 1'b0);

        // Random valid/ready against a byte queue model
        words_in = 0;
        cyc = 0;
        while (words_in < 1000 && cyc < 40000) begin
            s_if.tvalid = 1'($urandom_range(0, 1));
            s_if.tdata  = $urandom();
            m_if.tready = 1'($urandom_range(0, 1));
            #3;
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $error("FAIL rnd_extra_beat: observed %h expected none", m_if.tdata);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("rnd_beat", m_if.tdata, exp_b);
                end
            end
            if (s_if.tvalid && s_if.tready) begin
                for (int b = 0; b < 4; b++) exp_q.push_back(s_if.tdata[8*b +: 8]);
                words_in++;
            end
            tick();
            cyc++;
        end
        chk("rnd_words_sent", words_in, 1000);

        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            #3;
            if (m_if.tvalid) begin
                exp_b = exp_q.pop_front();
                chk("drain_beat", m_if.tdata, exp_b);
            end
            tick();
            cyc++;
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_idle", m_if.tvalid, 1'b0);

        // Reset in the middle of a word discards the remainder
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h44332211;
        tick();
        s_if.tvalid = 1'b0;
        chk("mr_b0", m_if.tdata, 8'h11);
        tick();
        chk("mr_b1_pre", m_if.tdata, 8'h22);
        rstn = 1'b0;
        #1;
        chk("mr_rst_valid", m_if.tvalid, 1'b0);
        chk("mr_rst_data", m_if.tdata, 8'h00);
        tick();
        tick();
        rstn = 1'b1;
        #1;
        chk("mr_rel_valid", m_if.tvalid, 1'b0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h88776655;
        tick();
        s_if.tvalid = 1'b0;
        chk("mr_n0", m_if.tdata, 8'h55);
        tick();
        chk("mr_n1", m_if.tdata, 8'h66);
        tick();
        chk("mr_n2", m_if.tdata, 8'h77);
        tick();
        chk("mr_n3", m_if.tdata, 8'h88);
        chk("mr_n3_last", m_if.tlast_slice, 1'b1);
        tick();
        chk("mr_idle", m_if.tvalid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_axis_width_downsizer
`default_nettype wire
